// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter: serializer state
// encoding, default requester count and baud divisor, grant-id width, and the
// round-robin index helper.
package uart_arb_pkg;

  localparam int NREQ_DEFAULT     = 4;
  localparam int BAUD_DIV_DEFAULT = 434;  // 50 MHz / 115200
  localparam int GRANT_W          = 2;    // enough for up to 4 requesters
  localparam int DATA_BITS        = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Requester index 'offset' positions after 'base', wrapping at n.
  function automatic logic [GRANT_W-1:0] rr_index(input logic [GRANT_W-1:0] base,
                                                  input int offset,
                                                  input int n);
    return GRANT_W'((int'(base) + offset) % n);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART frame serializer: bit-period counter, shift register and
// START/DATA/STOP sequencing. A load pulse in IDLE captures a byte; the line
// drops low on the following cycle and each bit lasts exactly BAUD_DIV cycles.
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       io_clk,
  input  logic       io_rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int              CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  uart_state_e      r_state;
  uart_state_e      w_next_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_bit_end;

  // Last cycle of the current bit period.
  assign w_bit_end = (r_state != IDLE) && (r_bit_cnt == CNT_LAST);

  // State register; async reset returns the line to idle immediately.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      r_state <= w_next_state;
    end
  end

  // Next-state: advance on bit boundaries, leave DATA after the eighth bit.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (otherwise a latch is inferred).
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (i_load) w_next_state = START;
      START:   if (w_bit_end) w_next_state = DATA;
      DATA:    if (w_bit_end && (r_bit_idx == 3'(DATA_BITS - 1))) w_next_state = STOP;
      STOP:    if (w_bit_end) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Bit counter, data-bit index and shift register.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      if (i_load) r_shift <= i_data;
    end else if (w_bit_end) begin
      r_bit_cnt <= '0;
      if (r_state == DATA) begin
        r_shift   <= {1'b0, r_shift[7:1]};  // LSB first
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end else begin
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // Line and busy decode from the registered state.
  always_comb begin
    o_busy = (r_state != IDLE);
    o_tx   = 1'b1;
    case (r_state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = r_shift[0];
      default: o_tx = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding NREQ byte requesters into one UART transmitter.
// One handshake per frame, taken only while the serializer is idle.
// Optional packet lock: define UART_ARB_LOCK_EN to hold arbitration on one
// requester from a req_last=0 byte until its req_last=1 byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEFAULT,
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                io_clk,
  input  logic                io_rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_last,
  output logic [NREQ-1:0]     req_ready,
  output logic                io_uart_tx,
  output logic                busy,
  output logic [GRANT_W-1:0]  grant_id
);

  logic [GRANT_W-1:0] r_grant_id;
  logic [NREQ-1:0]    w_mask;
  logic [NREQ-1:0]    w_eligible;
  logic               w_found;
  logic [GRANT_W-1:0] w_win_idx;
  logic               w_hs;
  logic               w_busy;
  logic [7:0]         w_win_data;

`ifdef UART_ARB_LOCK_EN
  logic r_lock;

  // Packet lock: a byte without req_last pins arbitration to its requester.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_lock <= 1'b0;
    end else if (w_hs) begin
      r_lock <= ~req_last[w_win_idx];
    end
  end

  assign w_mask = r_lock ? (NREQ'(1) << r_grant_id) : '1;
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_mask        = '1;
`endif

  assign w_eligible = req_valid & w_mask;

  // Round-robin search starting one past the last grant.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = r_grant_id;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && w_eligible[rr_index(r_grant_id, k, NREQ)]) begin
        w_found   = 1'b1;
        w_win_idx = rr_index(r_grant_id, k, NREQ);
      end
    end
  end

  assign w_hs       = w_found & ~w_busy & ~io_rst;
  assign req_ready  = w_hs ? (NREQ'(1) << w_win_idx) : '0;
  assign w_win_data = req_data[8*int'(w_win_idx) +: 8];

  // Grant register; reset to the last requester so requester 0 wins first.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      r_grant_id <= GRANT_W'(NREQ - 1);
    end else if (w_hs) begin
      r_grant_id <= w_win_idx;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = w_busy;

  uart_tx_serializer #(
    .BAUD_DIV (BAUD_DIV)
  ) u_serializer (
    .io_clk (io_clk),
    .io_rst (io_rst),
    .i_load (w_hs),
    .i_data (w_win_data),
    .o_busy (w_busy),
    .o_tx   (io_uart_tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NREQ=4, BAUD_DIV=4: reset values,
// a 0x55 frame waveform, a table of round-robin decisions with decoded bytes,
// back-to-back spacing, packet lock behaviour and reset in the middle of a frame.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int BAUD  = 4;
  localparam int FRAME = 10 * BAUD;

  logic        io_clk = 1'b0;
  logic        io_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data  = 32'h3C96_E10F;
  logic [3:0]  req_last  = 4'hF;
  logic [3:0]  req_ready;
  logic        io_uart_tx;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_grant;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t        vecs[9];
  logic [39:0] seq;
  logic [39:0] exp_seq;
  logic [7:0]  d55;
  int          busy_cnt;
  logic [3:0]  rdy_or;
  int          hs_cyc[5];
  int          hs_idx[5];
  int          n_hs;
  int          cyc;
  int          l1cnt;
  int          exp_rr[5];
  int          exp_pkt[4];

  always #5 io_clk = ~io_clk;

  uart_tx_arbiter #(
    .NREQ     (NREQ),
    .BAUD_DIV (BAUD)
  ) dut (
    .io_clk     (io_clk),
    .io_rst     (io_rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .io_uart_tx (io_uart_tx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called during the handshake cycle; records the 40 frame cycles that follow.
  task automatic capture_frame(output logic [39:0] s, output int bc, output logic [3:0] ro);
    @(posedge io_clk);
    #1;
    req_valid = '0;
    s  = '0;
    bc = 0;
    ro = '0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge io_clk);
      #1;
      s[c] = io_uart_tx;
      bc  += int'(busy);
      ro  |= req_ready;
    end
  endtask

  function automatic logic [7:0] decode(input logic [39:0] s);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = s[BAUD*(k+1) + BAUD/2];
    return b;
  endfunction

  function automatic int oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge io_clk);
      #1;
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin decisions; grant_id is 0 when the table starts.
    vecs[0] = '{4'b1111, 4'b0010, 2'd1, 8'hE1};
    vecs[1] = '{4'b0001, 4'b0001, 2'd0, 8'h0F};
    vecs[2] = '{4'b1000, 4'b1000, 2'd3, 8'h3C};
    vecs[3] = '{4'b0101, 4'b0001, 2'd0, 8'h0F};
    vecs[4] = '{4'b0101, 4'b0100, 2'd2, 8'h96};
    vecs[5] = '{4'b0011, 4'b0001, 2'd0, 8'h0F};
    vecs[6] = '{4'b1100, 4'b0100, 2'd2, 8'h96};
    vecs[7] = '{4'b0000, 4'b0000, 2'd2, 8'h00};
    vecs[8] = '{4'b1000, 4'b1000, 2'd3, 8'h3C};
    exp_rr = '{0, 1, 2, 3, 0};
`ifdef UART_ARB_LOCK_EN
    exp_pkt = '{1, 1, 1, 2};
`else
    exp_pkt = '{1, 2, 3, 0};
`endif

    // Reset values, with a request pending to show ready stays low.
    io_rst    = 1'b1;
    req_valid = 4'b0001;
    repeat (3) @(negedge io_clk);
    #1;
    check("rst_tx", io_uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant", grant_id, 3);
    req_valid = '0;
    io_rst    = 1'b0;
    @(negedge io_clk);
    #1;
    check("idle_busy", busy, 0);

    // Requester 0 sends 0x55.
    d55 = 8'h55;
    req_data[7:0] = d55;
    req_valid = 4'b0001;
    #1;
    check("b55_ready", req_ready, 4'b0001);
    capture_frame(seq, busy_cnt, rdy_or);
    for (int c = 0; c < FRAME; c++) begin
      case (c / BAUD)
        0:       exp_seq[c] = 1'b0;
        9:       exp_seq[c] = 1'b1;
        default: exp_seq[c] = d55[c/BAUD - 1];
      endcase
    end
    check("b55_wave", seq, exp_seq);
    check("b55_busy_cycles", busy_cnt, FRAME);
    check("b55_ready_in_frame", rdy_or, 0);
    check("b55_grant", grant_id, 0);
    @(negedge io_clk);
    #1;
    check("b55_end_busy", busy, 0);
    check("b55_end_tx", io_uart_tx, 1);
    req_data[7:0] = 8'h0F;

    // Table of single-frame arbitration decisions.
    for (int i = 0; i < 9; i++) begin
      req_valid = vecs[i].valid;
      #1;
      check($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
      if (vecs[i].exp_ready != 4'b0000) begin
        capture_frame(seq, busy_cnt, rdy_or);
        check($sformatf("vec%0d_byte", i), decode(seq), vecs[i].exp_byte);
        check($sformatf("vec%0d_busy_cycles", i), busy_cnt, FRAME);
        check($sformatf("vec%0d_grant", i), grant_id, vecs[i].exp_grant);
        @(negedge io_clk);
        #1;
        check($sformatf("vec%0d_end_busy", i), busy, 0);
      end else begin
        req_valid = '0;
        @(negedge io_clk);
        #1;
        check($sformatf("vec%0d_busy", i), busy, 0);
        check($sformatf("vec%0d_grant", i), grant_id, vecs[i].exp_grant);
      end
    end

    // All requesters valid continuously: order and handshake spacing.
    req_valid = 4'hF;
    n_hs = 0;
    cyc  = 0;
    #1;
    while (n_hs < 5 && cyc < 400) begin
      if (req_ready != 4'b0000) begin
        hs_cyc[n_hs] = cyc;
        hs_idx[n_hs] = oh2idx(req_ready);
        n_hs++;
      end
      @(negedge io_clk);
      #1;
      cyc++;
    end
    req_valid = '0;
    check("rr_handshakes", n_hs, 5);
    for (int i = 0; i < n_hs; i++)
      check($sformatf("rr_grant%0d", i), hs_idx[i], exp_rr[i]);
    for (int i = 1; i < n_hs; i++)
      check($sformatf("rr_gap%0d", i), hs_cyc[i] - hs_cyc[i-1], FRAME + 1);
    wait_idle("rr_idle");
    check("rr_final_grant", grant_id, 0);

    // Requester 1 sends a 3-byte packet while everyone else is also valid.
    req_last  = 4'b1101;
    req_valid = 4'hF;
    n_hs  = 0;
    cyc   = 0;
    l1cnt = 0;
    #1;
    while (n_hs < 4 && cyc < 400) begin
      if (req_ready != 4'b0000) begin
        hs_idx[n_hs] = oh2idx(req_ready);
        n_hs++;
        if (req_ready == 4'b0010) begin
          l1cnt++;
          @(posedge io_clk);
          #1;
          req_last[1] = (l1cnt == 2);
        end
      end
      @(negedge io_clk);
      #1;
      cyc++;
    end
    req_valid = '0;
    check("pkt_handshakes", n_hs, 4);
    for (int i = 0; i < n_hs; i++)
      check($sformatf("pkt_grant%0d", i), hs_idx[i], exp_pkt[i]);
    wait_idle("pkt_idle");
    req_last = 4'hF;

    // Reset during DATA bit 3 of a 0xE1 frame from requester 1.
    req_valid = 4'b0010;
    #1;
    check("abort_ready", req_ready, 4'b0010);
    @(posedge io_clk);
    #1;
    req_valid = '0;
    for (int c = 0; c <= 4*BAUD; c++) begin
      @(negedge io_clk);
      #1;
    end
    check("abort_bit3_tx", io_uart_tx, 0);
    check("abort_bit3_busy", busy, 1);
    check("abort_pre_grant", grant_id, 1);
    io_rst = 1'b1;
    #1;
    check("abort_tx", io_uart_tx, 1);
    check("abort_busy", busy, 0);
    check("abort_grant", grant_id, 3);
    req_valid = 4'hF;
    #1;
    check("abort_ready_in_rst", req_ready, 0);
    repeat (2) @(negedge io_clk);
    #1;
    io_rst = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    @(posedge io_clk);
    #1;
    req_valid = '0;
    check("post_rst_grant", grant_id, 0);
    check("post_rst_busy", busy, 1);
    wait_idle("post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
